// File: rtl/niosii_sys_key_pkg.sv
// Shared definitions for the key input port: register offsets and the
// debounce counter sizing rule.
package niosii_sys_key_pkg;

   localparam logic [1:0] RegData    = 2'd0;
   localparam logic [1:0] RegIrqmask = 2'd1;
   localparam logic [1:0] RegRsvd    = 2'd2;
   localparam logic [1:0] RegEdgecap = 2'd3;

   // One spare bit so the counter can never wrap before the compare hits.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/niosii_sys_key_debounce.sv
// One key bit: 2-flop synchronizer followed by a stable-count debouncer.
module niosii_sys_key_debounce
   import niosii_sys_key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter logic        RESET_LEVEL     = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din_i,
   output logic dout_o
);

   localparam int unsigned    CntW   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            deb_q, deb_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = din_i;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      if (sync2_q != deb_q) begin
         if (cnt_q == CntMax) begin
            deb_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= RESET_LEVEL;
         sync2_q <= RESET_LEVEL;
         deb_q   <= RESET_LEVEL;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout_o = deb_q;

endmodule

// File: rtl/niosii_sys_key.sv
// Avalon-MM key input port: debounced data, irq mask, falling-edge capture
// with write-1-to-clear, registered read data and level interrupt.
module niosii_sys_key
   import niosii_sys_key_pkg::*;
#(
   parameter int unsigned      WIDTH           = 4,
   parameter int unsigned      DEBOUNCE_CYCLES = 50000,
   parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] fall;
   logic             wr_en;
   logic [WIDTH-1:0] deb_prev_q, deb_prev_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] ec_q, ec_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             irq_q, irq_d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      niosii_sys_key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RESET_LEVEL    (RESET_LEVEL[i])
      ) u_debounce (
         .clk    (clk),
         .reset_n(reset_n),
         .din_i  (in_port[i]),
         .dout_o (deb[i])
      );
   end

   if (WIDTH < 32) begin : g_unused
      logic unused_wd;
      assign unused_wd = ^writedata[31:WIDTH];
   end

   always_comb begin
      wr_en      = chipselect & ~write_n;
      fall       = deb_prev_q & ~deb;
      deb_prev_d = deb;

      mask_d = mask_q;
      if (wr_en && (address == RegIrqmask)) begin
         mask_d = writedata[WIDTH-1:0];
      end

      // Clear first, then OR in new events so a same-cycle edge survives.
      ec_d = ec_q;
      if (wr_en && (address == RegEdgecap)) begin
         ec_d = ec_q & ~writedata[WIDTH-1:0];
      end
      ec_d = ec_d | fall;

      irq_d = |(ec_d & mask_d);

      rdata_d = '0;
      if (chipselect) begin
         unique case (address)
            RegData:    rdata_d[WIDTH-1:0] = deb;
            RegIrqmask: rdata_d[WIDTH-1:0] = mask_q;
            RegRsvd:    rdata_d            = '0;
            RegEdgecap: rdata_d[WIDTH-1:0] = ec_q;
            default:    rdata_d            = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_prev_q <= RESET_LEVEL;
         mask_q     <= '0;
         ec_q       <= '0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         deb_prev_q <= deb_prev_d;
         mask_q     <= mask_d;
         ec_q       <= ec_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = rdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_niosii_sys_key.sv
// Directed and randomized checks of the key port against a cycle-level model.
module tb_niosii_sys_key;

   localparam int unsigned W  = 4;
   localparam int unsigned DC = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic [1:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [W-1:0]  in_port = '1;
   logic [31:0]   readdata;
   logic          irq;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   logic [W-1:0] m_s1, m_s2, m_deb, m_deb_prev, m_mask, m_ec;
   logic [31:0]  m_rd;
   logic         m_irq;
   int           m_run[W];

   niosii_sys_key #(
      .WIDTH          (W),
      .DEBOUNCE_CYCLES(DC),
      .RESET_LEVEL    (4'hF)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .in_port   (in_port),
      .readdata  (readdata),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_reg(input logic [1:0] a);
      case (a)
         2'd0:    return {28'b0, m_deb};
         2'd1:    return {28'b0, m_mask};
         2'd3:    return {28'b0, m_ec};
         default: return 32'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_s1 = '1; m_s2 = '1; m_deb = '1; m_deb_prev = '1;
      m_mask = '0; m_ec = '0; m_rd = '0; m_irq = 1'b0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
   endtask

   // A bit flips once its synchronized input has disagreed for DC straight edges.
   task automatic model_step();
      logic         wr;
      logic [W-1:0] fall;
      logic [W-1:0] new_deb;
      wr   = chipselect && !write_n;
      m_rd = chipselect ? m_reg(address) : 32'b0;
      fall = m_deb_prev & ~m_deb;
      if (wr && address == 2'd3) m_ec = m_ec & ~writedata[W-1:0];
      m_ec = m_ec | fall;
      if (wr && address == 2'd1) m_mask = writedata[W-1:0];
      m_irq = |(m_ec & m_mask);
      new_deb = m_deb;
      for (int i = 0; i < W; i++) begin
         if (m_s2[i] != m_deb[i]) begin
            m_run[i]++;
            if (m_run[i] == DC) begin
               new_deb[i] = m_s2[i];
               m_run[i]   = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_deb_prev = m_deb;
      m_deb      = new_deb;
      m_s2       = m_s1;
      m_s1       = in_port;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("readdata", readdata, m_rd);
      chk("irq", {31'b0, irq}, {31'b0, m_irq});
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; address = a; write_n = 1'b0; writedata = d;
      step();
      write_n = 1'b1;
   endtask

   initial begin
      logic [31:0] exp_rst[4];
      int hold;
      exp_rst = '{32'hF, 32'h0, 32'h0, 32'h0};
      model_reset();

      // Reset values of all offsets
      #1;
      do_reset();
      chipselect = 1'b1;
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         step();
         chk($sformatf("reset_off%0d", a), readdata, exp_rst[a]);
      end

      // Press key 0: data follows after 2 + DC + 1 edges, edge captured
      address = 2'd0;
      in_port = 4'b1110;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (c == 6) chk("data_before_deb", readdata, 32'hF);
         if (c == 7) chk("data_after_deb", readdata, 32'hE);
      end
      address = 2'd3;
      step();
      chk("ec_after_press", readdata, 32'h1);
      chk("irq_masked", {31'b0, irq}, 32'h0);

      // Bounce on bit 1 faster than the debounce window
      address = 2'd0;
      for (int c = 0; c < 20; c++) begin
         if (c % 2 == 0) in_port[1] = ~in_port[1];
         step();
      end
      in_port = 4'b1110;
      for (int c = 0; c < 4; c++) step();
      chk("bounce_data", readdata, 32'hE);
      address = 2'd3;
      step();
      chk("bounce_ec", readdata, 32'h1);

      // Unmask bit 0, then clear it
      bus_write(2'd1, 32'h1);
      chk("irq_on_mask", {31'b0, irq}, 32'h1);
      bus_write(2'd3, 32'h1);
      chk("irq_off_clear", {31'b0, irq}, 32'h0);
      address = 2'd3;
      step();
      chk("ec_cleared", readdata, 32'h0);

      // Bit 2 edge lands on the same edge as its clear
      address = 2'd0;
      in_port = 4'b1010;
      for (int c = 0; c < 6; c++) step();
      bus_write(2'd3, 32'h4);
      address = 2'd3;
      step();
      chk("set_wins", readdata, 32'h4);

      // Randomized bus and key activity
      hold = 0;
      for (int c = 0; c < 400; c++) begin
         if (hold == 0) begin
            in_port = 4'($urandom);
            hold    = $urandom_range(1, 8);
         end
         hold--;
         chipselect = 1'($urandom);
         address    = 2'($urandom);
         write_n    = ($urandom_range(0, 3) != 0);
         writedata  = $urandom;
         step();
      end
      write_n = 1'b1;

      // Reset in the middle of a debounce count
      chipselect = 1'b1;
      address    = 2'd0;
      in_port    = 4'hF;
      for (int c = 0; c < 10; c++) step();
      in_port = 4'hE;
      for (int c = 0; c < 4; c++) step();
      do_reset();
      step();
      chk("mid_rst_data", readdata, 32'hF);
      address = 2'd3;
      for (int c = 2; c <= 8; c++) begin
         step();
         if (c == 7) chk("mid_rst_no_ec", readdata, 32'h0);
         if (c == 8) chk("mid_rst_ec", readdata, 32'h1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
